// File: rtl/usr_c2h_pkg.sv
// Shared definitions for the C2H packetizer: write-FSM encoding, default
// parameter values and counter widths.
package usr_c2h_pkg;

  localparam int unsigned DATA_W_DEF     = 128;
  localparam int unsigned PKT_BEATS_DEF  = 256;
  localparam int unsigned FIFO_DEPTH_DEF = 512;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned TUSER_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_CLOSE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/usr_c2h_fifo.sv
// Synchronous FIFO with registered full/empty flags and a first-word-fall-through
// read port; a synchronous clear empties it in one cycle.
module usr_c2h_fifo #(
  parameter int unsigned W     = 129,
  parameter int unsigned DEPTH = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_c_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  logic          push, pop;

  assign push = wr_en_i & ~full_q & ~clr_i;
  assign pop  = rd_en_i & ~empty_q & ~clr_i;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage is left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_c_o = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule

// File: rtl/usr_c2h_pktz.sv
// C2H packetizer: frames a free-running capture stream into fixed-length
// AXI-Stream packets, closing short packets on stop and raising an irq.
module usr_c2h_pktz
  import usr_c2h_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned PKT_BEATS  = PKT_BEATS_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                usr_clk,
  input  logic                usr_rst,
  input  logic                s0_axis_c2h_rst_i,
  input  logic                usr_c2h0r_run_i,
  output logic                c2h0r_run_o,
  input  logic [DATA_W-1:0]   pcie_data,
  input  logic                pcie_valid,
  input  logic                pcie_start,
  input  logic                pcie_stop,
  output logic [DATA_W-1:0]   s0_axis_c2h_tdata_o,
  output logic [DATA_W/8-1:0] s0_axis_c2h_tkeep_o,
  output logic [TUSER_W-1:0]  s0_axis_c2h_tuser_o,
  output logic                s0_axis_c2h_tlast_o,
  output logic                s0_axis_c2h_tvalid_o,
  input  logic                s0_axis_c2h_tready_i,
  output logic                usr_c2h0irq_req_o,
  input  logic                usr_c2h0irq_ack_i,
  output logic                usr_c2h0err_o
);

  localparam int unsigned     FW       = DATA_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_BEATS - 1);

  wr_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, ocnt_q, ocnt_d;
  logic              err_q, err_d, irq_q, irq_d;
  logic              run_q, run_d1_q;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d, tvalid_q, tvalid_d;

  logic              wr_req, wr_last, wr_zero;
  logic              fifo_rd, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_wdata, fifo_rdata;
  logic              hs, stop_hs;

  // Write side: frame incoming beats and decide what enters the FIFO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_req  = 1'b0;
    wr_last = 1'b0;
    wr_zero = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pcie_start && !pcie_stop) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (pcie_stop) begin
          if (pcie_valid) begin
            wr_req  = 1'b1;
            wr_last = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q != '0) begin
            state_d = ST_CLOSE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (pcie_valid) begin
          wr_req  = 1'b1;
          wr_last = (cnt_q == LAST_CNT);
          if (!fifo_full) cnt_d = wr_last ? '0 : cnt_q + 1'b1;
        end
      end
      ST_CLOSE: begin
        wr_req  = 1'b1;
        wr_last = 1'b1;
        wr_zero = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = err_q | (wr_req & fifo_full) | (state_q == ST_CLOSE);
    if (s0_axis_c2h_rst_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
      wr_req  = 1'b0;
    end
  end

  assign fifo_wdata = {wr_last, (wr_zero ? {DATA_W{1'b0}} : pcie_data)};

  usr_c2h_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (usr_clk),
    .rst         (usr_rst),
    .clr_i       (s0_axis_c2h_rst_i),
    .wr_en_i     (wr_req),
    .wr_data_i   (fifo_wdata),
    .rd_en_i     (fifo_rd),
    .rd_data_c_o (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign hs      = tvalid_q & s0_axis_c2h_tready_i;
  assign fifo_rd = ~fifo_empty & (~tvalid_q | s0_axis_c2h_tready_i) & ~s0_axis_c2h_rst_i;
  // A tlast off the natural packet boundary can only come from a stop.
  assign stop_hs = hs & tlast_q & (ocnt_q != LAST_CNT);

  // Output slot, outgoing beat position and interrupt request.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    ocnt_d   = ocnt_q;
    irq_d    = irq_q;
    if (hs) begin
      tvalid_d = 1'b0;
      ocnt_d   = tlast_q ? '0 : ocnt_q + 1'b1;
    end
    if (fifo_rd) begin
      tvalid_d           = 1'b1;
      {tlast_d, tdata_d} = fifo_rdata;
    end
    if (usr_c2h0irq_ack_i) irq_d = 1'b0;
    if (stop_hs)           irq_d = 1'b1;
    if (s0_axis_c2h_rst_i) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      ocnt_d   = '0;
      irq_d    = 1'b0;
    end
  end

  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ocnt_q   <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      run_q    <= 1'b0;
      run_d1_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ocnt_q   <= ocnt_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
      run_q    <= usr_c2h0r_run_i;
      run_d1_q <= run_q;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign c2h0r_run_o          = run_q & ~run_d1_q;
  assign s0_axis_c2h_tdata_o  = tdata_q;
  assign s0_axis_c2h_tkeep_o  = '1;
  assign s0_axis_c2h_tuser_o  = '0;
  assign s0_axis_c2h_tlast_o  = tlast_q;
  assign s0_axis_c2h_tvalid_o = tvalid_q;
  assign usr_c2h0irq_req_o    = irq_q;
  assign usr_c2h0err_o        = err_q;

endmodule

// File: tb/tb_usr_c2h_pktz.sv
// Self-checking bench for usr_c2h_pktz: directed scenarios plus randomized
// packets checked against a packet-level expected-beat queue.
module tb_usr_c2h_pktz;

  localparam int unsigned DW    = 128;
  localparam int unsigned PKT   = 256;
  localparam int unsigned DEPTH = 512;

  logic          usr_clk = 1'b0;
  logic          usr_rst, flush, run_i, run_o;
  logic [DW-1:0] pdata;
  logic          pvalid, pstart, pstop;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tkeep;
  logic [15:0]   tuser;
  logic          tlast, tvalid, tready;
  logic          irq_req, irq_ack, err;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW+1:0] exp_q [$];   // {stop_generated, last, data}
  logic [DW+1:0] e;
  bit            rnd_ready = 1'b0;
  bit            irq_pend = 1'b0;
  bit            hold_v = 1'b0;
  logic [DW:0]   hold_beat;

  always #5 usr_clk = ~usr_clk;

  usr_c2h_pktz #(
    .DATA_W     (DW),
    .PKT_BEATS  (PKT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .usr_clk              (usr_clk),
    .usr_rst              (usr_rst),
    .s0_axis_c2h_rst_i    (flush),
    .usr_c2h0r_run_i      (run_i),
    .c2h0r_run_o          (run_o),
    .pcie_data            (pdata),
    .pcie_valid           (pvalid),
    .pcie_start           (pstart),
    .pcie_stop            (pstop),
    .s0_axis_c2h_tdata_o  (tdata),
    .s0_axis_c2h_tkeep_o  (tkeep),
    .s0_axis_c2h_tuser_o  (tuser),
    .s0_axis_c2h_tlast_o  (tlast),
    .s0_axis_c2h_tvalid_o (tvalid),
    .s0_axis_c2h_tready_i (tready),
    .usr_c2h0irq_req_o    (irq_req),
    .usr_c2h0irq_ack_i    (irq_ack),
    .usr_c2h0err_o        (err)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void push_exp(input logic [DW-1:0] d, input bit last, input bit stop);
    exp_q.push_back({stop, last, d});
  endfunction

  task automatic tick();
    @(posedge usr_clk);
    #1;
    if (rnd_ready) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    chk("drain", 256'(exp_q.size()), 256'(0));
    tick();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
  endtask

  // Output monitor: order/content, hold stability and irq rise after stop-lasts.
  always @(negedge usr_clk) begin
    if (usr_rst) begin
      hold_v   = 1'b0;
      irq_pend = 1'b0;
    end else begin
      if (irq_pend) begin
        chk("irq_rise", 256'(irq_req), 256'(1));
        irq_pend = 1'b0;
      end
      if (hold_v) chk("hold", 256'({tvalid, tlast, tdata}), 256'({1'b1, hold_beat}));
      hold_v    = tvalid && !tready && !flush;
      hold_beat = {tlast, tdata};
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 256'(tvalid & tready), 256'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat", 256'({tlast, tdata}), 256'(e[DW:0]));
          if (e[DW+1] && !flush) irq_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d beats pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int            sent, closes, len, kind, i;
    bit            endp;

    usr_rst = 1'b1; flush = 1'b0; run_i = 1'b0; pdata = '0; pvalid = 1'b0;
    pstart = 1'b0; pstop = 1'b0; tready = 1'b0; irq_ack = 1'b0;
    repeat (3) @(posedge usr_clk);
    #1;
    chk("rst_tvalid", 256'(tvalid), 256'(0));
    chk("rst_tlast",  256'(tlast),  256'(0));
    chk("rst_tdata",  256'(tdata),  256'(0));
    chk("rst_tkeep",  256'(tkeep),  256'({(DW/8){1'b1}}));
    chk("rst_tuser",  256'(tuser),  256'(0));
    chk("rst_err",    256'(err),    256'(0));
    chk("rst_irq",    256'(irq_req), 256'(0));
    chk("rst_run",    256'(run_o),  256'(0));
    usr_rst = 1'b0;
    tick();

    // run edge detect: single-cycle pulse
    run_i = 1'b1;
    chk("run_pre", 256'(run_o), 256'(0));
    tick();
    chk("run_pulse", 256'(run_o), 256'(1));
    tick();
    chk("run_once", 256'(run_o), 256'(0));
    run_i = 1'b0;

    // 512 continuous beats, full-length packets
    tready = 1'b1;
    pstart = 1'b1; tick(); pstart = 1'b0;
    for (int k = 0; k < 512; k++) begin
      d = rnd_data();
      push_exp(d, (k % PKT) == PKT - 1, 1'b0);
      pvalid = 1'b1; pdata = d; tick();
    end
    pvalid = 1'b0;
    wait_drain(100);
    chk("full_err", 256'(err), 256'(0));
    chk("full_irq", 256'(irq_req), 256'(0));
    pstop = 1'b1; tick(); pstop = 1'b0;
    repeat (5) tick();
    chk("stop0_err", 256'(err), 256'(0));
    chk("stop0_noclose", 256'(tvalid), 256'(0));

    // latency, then 10-beat packet closed by stop with valid
    tready = 1'b0;
    pstart = 1'b1; tick(); pstart = 1'b0;
    d = rnd_data(); push_exp(d, 1'b0, 1'b0);
    pvalid = 1'b1; pdata = d; tick(); pvalid = 1'b0;
    chk("lat_n1", 256'(tvalid), 256'(0));
    tick();
    chk("lat_n2", 256'(tvalid), 256'(1));
    tready = 1'b1;
    for (int k = 1; k < 10; k++) begin
      d = rnd_data(); push_exp(d, k == 9, k == 9);
      pvalid = 1'b1; pdata = d; pstop = (k == 9); tick();
    end
    pvalid = 1'b0; pstop = 1'b0;
    wait_drain(50);
    repeat (3) tick();
    chk("irq_hold", 256'(irq_req), 256'(1));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("irq_clear", 256'(irq_req), 256'(0));
    chk("stopv_err", 256'(err), 256'(0));

    // 5 beats then stop alone -> zero closing beat and error
    pstart = 1'b1; tick(); pstart = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d = rnd_data(); push_exp(d, 1'b0, 1'b0);
      pvalid = 1'b1; pdata = d; tick();
    end
    pvalid = 1'b0;
    push_exp('0, 1'b1, 1'b1);
    pstop = 1'b1; tick(); pstop = 1'b0;
    wait_drain(50);
    chk("close_err", 256'(err), 256'(1));
    repeat (10) tick();
    chk("err_sticky", 256'(err), 256'(1));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    pulse_flush();
    chk("flush_err_clr", 256'(err), 256'(0));

    // overflow with sink stalled: 512 in FIFO + 1 in slot survive
    tready = 1'b0;
    pstart = 1'b1; tick(); pstart = 1'b0;
    for (int k = 0; k < 520; k++) begin
      d = rnd_data();
      if (k < DEPTH + 1) push_exp(d, (k % PKT) == PKT - 1, 1'b0);
      pvalid = 1'b1; pdata = d; tick();
    end
    pvalid = 1'b0;
    chk("ovf_err", 256'(err), 256'(1));
    tready = 1'b1;
    wait_drain(700);
    repeat (5) tick();
    pulse_flush();

    // randomized packets, random sink ready
    rnd_ready = 1'b1;
    sent = 0; closes = 0;
    while (sent < 1000) begin
      len  = $urandom_range(1, 300);
      kind = $urandom_range(0, 2);
      // keep stop-generated lasts off the natural packet boundary
      if (kind != 1 && ((len - 1) % PKT) == PKT - 1) len++;
      if (kind == 1 && (len % PKT) == PKT - 1) len++;
      repeat ($urandom_range(0, 3)) begin
        pvalid = 1'($urandom_range(0, 1)); pdata = rnd_data(); tick();
      end
      pstart = 1'b1; pvalid = 1'($urandom_range(0, 1)); pdata = rnd_data(); tick();
      pstart = 1'b0;
      i = 0;
      while (i < len) begin
        pvalid = 1'($urandom_range(0, 1));
        pdata  = rnd_data();
        if (pvalid) begin
          endp = (kind != 1) && (i == len - 1);
          push_exp(pdata, ((i % PKT) == PKT - 1) || endp, endp);
          pstop  = endp;
          pstart = endp && (kind == 2);
          i++;
        end
        tick();
        pstop = 1'b0; pstart = 1'b0;
      end
      if (kind == 1) begin
        pvalid = 1'b0; pstop = 1'b1; tick(); pstop = 1'b0;
        if ((len % PKT) != 0) begin
          push_exp('0, 1'b1, 1'b1);
          closes++;
        end
        pvalid = 1'($urandom_range(0, 1)); pdata = rnd_data(); tick();
      end
      pvalid = 1'b0;
      sent += len;
    end
    wait_drain(6000);
    rnd_ready = 1'b0; tready = 1'b1;
    chk("rand_err", 256'(err), 256'(closes != 0));

    // flush mid-packet with a pending error and buffered data
    tready = 1'b0;
    pstart = 1'b1; tick(); pstart = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pvalid = 1'b1; pdata = rnd_data(); tick();
    end
    pvalid = 1'b0; pstop = 1'b1; tick(); pstop = 1'b0;
    tick();
    pstart = 1'b1; tick(); pstart = 1'b0;
    for (int k = 0; k < 50; k++) begin
      pvalid = 1'b1; pdata = rnd_data(); tick();
    end
    chk("pre_flush_err", 256'(err), 256'(1));
    pvalid = 1'b1; pdata = rnd_data();
    pulse_flush();
    pvalid = 1'b0;
    chk("flush_tvalid", 256'(tvalid), 256'(0));
    chk("flush_err", 256'(err), 256'(0));
    chk("flush_irq", 256'(irq_req), 256'(0));
    tready = 1'b1;
    repeat (3) tick();
    pstart = 1'b1; tick(); pstart = 1'b0;
    for (int k = 0; k < 300; k++) begin
      d = rnd_data(); push_exp(d, (k % PKT) == PKT - 1, 1'b0);
      pvalid = 1'b1; pdata = d; tick();
    end
    pvalid = 1'b0;
    wait_drain(100);
    pulse_flush();

    // reset mid-packet: buffered data vanishes, no tlast afterwards
    tready = 1'b0;
    pstart = 1'b1; tick(); pstart = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pvalid = 1'b1; pdata = rnd_data(); tick();
    end
    pvalid = 1'b0;
    usr_rst = 1'b1;
    #1;
    chk("midrst_tvalid", 256'(tvalid), 256'(0));
    chk("midrst_tlast", 256'(tlast), 256'(0));
    tick();
    usr_rst = 1'b0;
    tready = 1'b1;
    repeat (10) tick();
    chk("post_rst_tvalid", 256'(tvalid), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usr_c2h_pktz.md
USR_C2H_PKTZ -- requirements
Module: usr_c2h_pktz

Interface
REQ-001 SHALL have parameter DATA_W, default 128, stream data width in bits (multiple of 64).
REQ-002 SHALL have parameter PKT_BEATS, default 256, beats per full packet (2..65535).
REQ-003 SHALL have parameter FIFO_DEPTH, default 512, buffer depth in beats (power of two, at least 4).
REQ-004 SHALL have port usr_clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port usr_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port s0_axis_c2h_rst_i  in  1  synchronous channel flush.
REQ-007 SHALL have port usr_c2h0r_run_i  in  1  DMA run level.
REQ-008 SHALL have port c2h0r_run_o  out  1  one-cycle pulse on run rising edge (two-flop edge detect).
REQ-009 SHALL have port pcie_data  in  DATA_W  source beat.
REQ-010 SHALL have port pcie_valid  in  1  source beat valid (no back-pressure to source).
REQ-011 SHALL have ports pcie_start and pcie_stop  in  1 each  capture open/close strobes.
REQ-012 SHALL have ports s0_axis_c2h_tdata_o/tkeep_o/tuser_o/tlast_o/tvalid_o  out  DATA_W/DATA_W/8/16/1/1  AXI-Stream master.
REQ-013 SHALL have port s0_axis_c2h_tready_i  in  1  AXI-Stream sink ready.
REQ-014 SHALL have ports usr_c2h0irq_req_o out 1 and usr_c2h0irq_ack_i in 1, end-of-capture interrupt handshake.
REQ-015 SHALL have port usr_c2h0err_o  out  1  sticky error (overflow or protocol).

Function
REQ-016 SHALL implement write FSM states IDLE, STREAM, CLOSE.
REQ-017 IDLE->STREAM on pcie_start; beats with pcie_valid in IDLE discarded, no error.
REQ-018 In STREAM each pcie_valid beat SHALL be written to FIFO as {last, data}; 16-bit write beat counter increments, wraps to 0 after PKT_BEATS-1; last=1 at count PKT_BEATS-1.
REQ-019 pcie_stop with pcie_valid SHALL write that beat with last=1, clear counter, go IDLE.
REQ-020 pcie_stop without pcie_valid and counter nonzero SHALL go CLOSE, then write one all-zero beat with last=1 next cycle, set error, go IDLE; counter zero: go IDLE directly.
REQ-021 pcie_start and pcie_stop together SHALL be treated as stop.
REQ-022 Beat arriving with FIFO full SHALL be dropped, error set, counter not advanced.
REQ-023 Output stage SHALL be a registered AXIS slot: tvalid held with tdata/tlast stable until tready; new beat loads same cycle as handshake (full throughput).
REQ-024 Latency: beat written at cycle N into empty FIFO SHALL show tvalid at N+2.
REQ-025 tkeep SHALL be all ones; tuser all zeros.
REQ-026 usr_c2h0irq_req_o SHALL rise the cycle after the handshake of a stop-generated last beat, hold until ack sampled high, then clear; a second event during req SHALL be merged.
REQ-027 Error SHALL be sticky until usr_rst or s0_axis_c2h_rst_i.
REQ-028 s0_axis_c2h_rst_i SHALL empty FIFO, drop output slot, clear counter, irq, error, FSM to IDLE next cycle; input beats that cycle discarded.

Reset
REQ-029 On usr_rst all outputs SHALL be 0 (tkeep all ones), FSM IDLE, counter 0, FIFO empty, edge-detect flops 0.
REQ-030 Reset mid-packet SHALL discard buffered data without emitting tlast.

Structure
REQ-031 Package usr_c2h_pkg SHALL hold FSM state encoding, default parameter values, counter width 16.
REQ-032 SHALL instantiate one sub-module usr_c2h_fifo (sync FIFO, width DATA_W+1, full/empty, depth FIFO_DEPTH).

Verification
REQ-033 start, 512 continuous beats, tready=1 -> 512 beats out, tlast on beats 255 and 511, no error.
REQ-034 start, 10 beats, stop with 10th valid -> tlast on beat 10, irq_req rises; ack -> req clears next cycle.
REQ-035 start, 5 beats, stop alone -> 6 beats out, 6th zero with tlast, error=1.
REQ-036 tready=0, 520 beats at DEPTH 512 -> error=1, then tready=1 yields exactly 513 beats (512 FIFO + slot), order intact.
REQ-037 tready toggling 50% random, 1000 beats -> data order and tdata stability under tvalid&!tready hold.
REQ-038 s0_axis_c2h_rst_i pulse mid-packet -> tvalid=0 next cycle, error clear, next packet's tlast at beat 256 after new start.
